// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: Avalon-MM CSRs, an 8-entry pattern table stepped at a prescaled rate, PWM dimming.
// Latency: read data 1 cycle after avs_read, led_export 1 cycle after step/PAT/DUTY change; never stalls the bus.
module led_pattern_sequencer #(
  parameter int N_LED            = 4,
  parameter int PWM_BITS         = 8,
  parameter int DEFAULT_PRESCALE = 49999999
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [3:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic [N_LED-1:0] led_export,
  output logic             irq
);

  // The 1 step/s default does not fit in 24 bits, so the prescaler widens to hold it.
  localparam int PRESC_W = ($clog2(DEFAULT_PRESCALE + 1) > 24) ? $clog2(DEFAULT_PRESCALE + 1) : 24;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           step_q, step_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 wrap_set;

  logic                 en_q, oneshot_q, irq_en_q, wrap_q;
  logic [PRESC_W-1:0]   prescale_q;
  logic [2:0]           len_q;
  logic [PWM_BITS-1:0]  duty_q, pwm_q;
  logic [N_LED-1:0]     pat_q [8];
  logic                 lit;
  logic [31:0]          rd_mux;
  logic                 unused_wdata;

  wire ctrl_wr   = avs_write && (avs_address == 4'h0);
  wire status_wr = avs_write && (avs_address == 4'h1);

  assign unused_wdata = ^avs_writedata[31:PRESC_W];

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    presc_d  = presc_q;
    wrap_set = 1'b0;
    if (ctrl_wr) begin
      state_d = avs_writedata[0] ? ST_RUN : ST_IDLE;
      step_d  = '0;
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      // >= rather than == so shrinking PRESCALE or LEN mid-run acts at once
      if (presc_q >= prescale_q) begin
        presc_d = '0;
        if (step_q >= len_q) begin
          wrap_set = 1'b1;
          if (oneshot_q) state_d = ST_DONE;
          else           step_d  = '0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      presc_q <= presc_d;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      en_q       <= 1'b0;
      oneshot_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      wrap_q     <= 1'b0;
      prescale_q <= PRESC_W'(DEFAULT_PRESCALE);
      len_q      <= 3'd7;
      duty_q     <= '1;
      for (int i = 0; i < 8; i++) pat_q[i] <= '0;
    end else begin
      // a wrap in the same cycle as a clear wins, so no wrap is ever lost
      wrap_q <= wrap_set | (wrap_q & ~(status_wr & avs_writedata[1]));
      if (avs_write) begin
        case (avs_address)
          4'h0: begin
            en_q      <= avs_writedata[0];
            oneshot_q <= avs_writedata[1];
            irq_en_q  <= avs_writedata[2];
          end
          4'h2:    prescale_q <= avs_writedata[PRESC_W-1:0];
          4'h3:    len_q      <= avs_writedata[2:0];
          4'h4:    duty_q     <= avs_writedata[PWM_BITS-1:0];
          default: if (avs_address[3]) pat_q[avs_address[2:0]] <= avs_writedata[N_LED-1:0];
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      4'h0:    rd_mux = {29'd0, irq_en_q, oneshot_q, en_q};
      4'h1:    rd_mux = {25'd0, step_q, 2'b00, wrap_q, (state_q == ST_RUN)};
      4'h2:    rd_mux = 32'(prescale_q);
      4'h3:    rd_mux = {29'd0, len_q};
      4'h4:    rd_mux = 32'(duty_q);
      default: if (avs_address[3]) rd_mux = 32'(pat_q[avs_address[2:0]]);
    endcase
  end

  assign lit = (pwm_q < duty_q) | (&duty_q);
  assign irq = wrap_q & irq_en_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pwm_q        <= '0;
      led_export   <= '0;
      avs_readdata <= '0;
    end else begin
      pwm_q        <= pwm_q + 1'b1;
      led_export   <= (state_q != ST_IDLE) ? (pat_q[step_q] & {N_LED{lit}}) : '0;
      avs_readdata <= avs_read ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer: register table plus cycle-exact sequences.
module tb_led_pattern_sequencer;

  logic        clk_clk;
  logic        reset_reset_n;
  logic [3:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [3:0]  led_export;
  logic        irq;

  led_pattern_sequencer dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .led_export    (led_export),
    .irq           (irq)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [18];
  vec_t        dflt [13];
  int          n_checks;
  int          n_fail;
  logic [31:0] rd;
  int          on_cnt, bad_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called on a falling edge; the write is sampled on the next rising edge.
  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    @(negedge clk_clk);
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge clk_clk);
    avs_read    = 1'b0;
    data        = avs_readdata;
  endtask

  task automatic count_lit(input int cycles, output int on, output int bad);
    on  = 0;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_clk);
      if (led_export == 4'hF) on++;
      else if (led_export != 4'h0) bad++;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 4'h1, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 4'h2, 32'h0,        32'd49999999};
    vecs[3]  = '{1'b0, 4'h3, 32'h0,        32'h7};
    vecs[4]  = '{1'b0, 4'h4, 32'h0,        32'hFF};
    vecs[5]  = '{1'b0, 4'h8, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 4'hF, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 4'h5, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 4'h5, 32'hFFFFFFFF, 32'h0};
    vecs[9]  = '{1'b1, 4'h3, 32'hFFFFFFFA, 32'h2};
    vecs[10] = '{1'b1, 4'h4, 32'h000001AB, 32'hAB};
    vecs[11] = '{1'b1, 4'h2, 32'h00000123, 32'h123};
    vecs[12] = '{1'b1, 4'hC, 32'h0000003A, 32'hA};
    vecs[13] = '{1'b1, 4'h9, 32'h00000005, 32'h5};
    vecs[14] = '{1'b0, 4'hC, 32'h0,        32'hA};
    vecs[15] = '{1'b1, 4'h0, 32'h00000006, 32'h6};
    vecs[16] = '{1'b0, 4'h1, 32'h0,        32'h0};
    vecs[17] = '{1'b1, 4'h7, 32'h00001234, 32'h0};

    dflt[0] = '{1'b0, 4'h0, 32'h0, 32'h0};
    dflt[1] = '{1'b0, 4'h1, 32'h0, 32'h0};
    dflt[2] = '{1'b0, 4'h2, 32'h0, 32'd49999999};
    dflt[3] = '{1'b0, 4'h3, 32'h0, 32'h7};
    dflt[4] = '{1'b0, 4'h4, 32'h0, 32'hFF};
    for (int i = 0; i < 8; i++) dflt[5 + i] = '{1'b0, 4'(8 + i), 32'h0, 32'h0};

    n_checks      = 0;
    n_fail        = 0;
    avs_address   = 4'h0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = 32'h0;
    reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    check("reset_led", led_export, 4'h0);
    check("reset_irq", irq, 1'b0);
    check("reset_rdata", avs_readdata, 32'h0);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    // register access table
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, rd);
      if (rd !== vecs[i].exp)
        $display("  table entry %0d addr 0x%0h", i, vecs[i].addr);
      check("reg_table", rd, vecs[i].exp);
    end
    check("idle_led", led_export, 4'h0);

    // sequence timing: 4 cycles per step, patterns 1,2,4, wrap after 12 cycles
    bus_write(4'h2, 32'd3);
    bus_write(4'h3, 32'd2);
    bus_write(4'h8, 32'h1);
    bus_write(4'h9, 32'h2);
    bus_write(4'hA, 32'h4);
    bus_write(4'h4, 32'hFF);
    bus_write(4'h1, 32'h2);
    bus_write(4'h0, 32'h5);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_clk);
      check("seq_led", led_export, 32'(4'(1 << ((i / 4) % 3))));
      check("seq_irq", irq, (i >= 11) ? 1'b1 : 1'b0);
    end
    bus_read(4'h1, rd);
    check("seq_status", rd, 32'h13);
    bus_write(4'h1, 32'h2);
    check("seq_w1c_irq", irq, 1'b0);
    bus_write(4'h0, 32'h0);

    // oneshot with irq
    bus_write(4'h2, 32'd0);
    bus_write(4'h3, 32'd1);
    bus_write(4'h8, 32'h3);
    bus_write(4'h9, 32'h5);
    bus_write(4'h0, 32'h7);
    check("os_led_t0", led_export, 4'h0);
    @(negedge clk_clk);
    check("os_led_t1", led_export, 4'h3);
    check("os_irq_t1", irq, 1'b0);
    @(negedge clk_clk);
    check("os_led_t2", led_export, 4'h5);
    check("os_irq_t2", irq, 1'b1);
    repeat (3) @(negedge clk_clk);
    check("os_led_hold", led_export, 4'h5);
    bus_read(4'h1, rd);
    check("os_status", rd, 32'h12);
    bus_write(4'h1, 32'h2);
    check("os_irq_clr", irq, 1'b0);
    check("os_led_after_clr", led_export, 4'h5);
    bus_write(4'h0, 32'h0);
    check("os_led_stop_lat", led_export, 4'h5);
    @(negedge clk_clk);
    check("os_led_stopped", led_export, 4'h0);

    // PWM duty
    bus_write(4'h8, 32'hF);
    bus_write(4'h3, 32'd0);
    bus_write(4'h4, 32'h40);
    bus_write(4'h0, 32'h1);
    repeat (2) @(negedge clk_clk);
    count_lit(256, on_cnt, bad_cnt);
    check("pwm40_on", on_cnt, 64);
    check("pwm40_partial", bad_cnt, 0);
    bus_write(4'h4, 32'h0);
    @(negedge clk_clk);
    count_lit(256, on_cnt, bad_cnt);
    check("pwm00_on", on_cnt, 0);
    bus_write(4'h4, 32'hFF);
    @(negedge clk_clk);
    count_lit(256, on_cnt, bad_cnt);
    check("pwmff_on", on_cnt, 256);
    bus_write(4'h0, 32'h0);

    // LEN shrunk below current step
    bus_write(4'h2, 32'd1);
    bus_write(4'h3, 32'd7);
    for (int i = 0; i < 8; i++) bus_write(4'(8 + i), 32'(i + 1));
    bus_write(4'h1, 32'h2);
    bus_write(4'h0, 32'h5);
    repeat (10) @(negedge clk_clk);
    bus_write(4'h3, 32'd2);
    check("len_irq_pre", irq, 1'b0);
    check("len_led_step5", led_export, 4'h6);
    @(negedge clk_clk);
    check("len_irq_wrap", irq, 1'b1);
    check("len_led_last", led_export, 4'h6);
    @(negedge clk_clk);
    check("len_led_step0", led_export, 4'h1);
    bus_write(4'h0, 32'h0);

    // PRESCALE shrunk below current count
    bus_write(4'h2, 32'd20);
    bus_write(4'h0, 32'h1);
    repeat (10) @(negedge clk_clk);
    bus_write(4'h2, 32'd0);
    check("presc_led_a", led_export, 4'h1);
    @(negedge clk_clk);
    check("presc_led_b", led_export, 4'h1);
    @(negedge clk_clk);
    check("presc_led_step1", led_export, 4'h2);
    @(negedge clk_clk);
    check("presc_led_step2", led_export, 4'h3);
    bus_write(4'h0, 32'h0);

    // W1C colliding with a wrap
    bus_write(4'h2, 32'd3);
    bus_write(4'h3, 32'd0);
    bus_write(4'h1, 32'h2);
    bus_write(4'h0, 32'h5);
    repeat (3) @(negedge clk_clk);
    check("race_irq_pre", irq, 1'b0);
    bus_write(4'h1, 32'h2);
    check("race_irq_kept", irq, 1'b1);
    bus_write(4'h1, 32'h2);
    check("race_irq_clr", irq, 1'b0);
    bus_write(4'h0, 32'h0);

    // read latency exactly one cycle
    avs_address = 4'h4;
    avs_read    = 1'b1;
    check("rd_lat0", avs_readdata, 32'h0);
    @(negedge clk_clk);
    avs_read = 1'b0;
    check("rd_lat1", avs_readdata, 32'hFF);
    @(negedge clk_clk);
    check("rd_lat2", avs_readdata, 32'h0);

    // asynchronous reset in the middle of a run
    bus_write(4'h2, 32'd0);
    bus_write(4'h8, 32'hF);
    bus_write(4'h0, 32'h5);
    repeat (3) @(negedge clk_clk);
    check("mrst_led_pre", led_export, 4'hF);
    check("mrst_irq_pre", irq, 1'b1);
    avs_address = 4'h4;
    avs_read    = 1'b1;
    @(posedge clk_clk);
    #2;
    check("mrst_rd_pre", avs_readdata, 32'hFF);
    reset_reset_n = 1'b0;
    #1;
    check("mrst_led", led_export, 4'h0);
    check("mrst_irq", irq, 1'b0);
    check("mrst_rdata", avs_readdata, 32'h0);
    avs_read = 1'b0;
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    for (int i = 0; i < 13; i++) begin
      bus_read(dflt[i].addr, rd);
      check("mrst_defaults", rd, dflt[i].exp);
    end
    check("mrst_led_idle", led_export, 4'h0);
    check("mrst_irq_idle", irq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
